axi_lite_master: RTL and testbench
==================================

# axi_lite_master

AXI4-Lite initiator for the action control-register bus. It converts single-beat register commands from a local sequencer (a self-test or boot-time programmer of layer base addresses and start/done polling) into AXI-Lite write and read transactions toward the `axi_lite_slave` register file. Exactly one transaction is outstanding at a time. Each command produces exactly one response on a valid/ready response port.

## Interface
Parameters:
- DATA_WIDTH, 32, AXI-Lite data width (32 only)
- ADDR_WIDTH, 32, AXI-Lite address width
- TIMEOUT_CYCLES, 1024, watchdog limit; used only when the timeout feature is compiled in

Ports (one clock; reset is asynchronous and active-low):
- ap_clk  in  1  clock
- ap_rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  register byte address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_wstrb  in  DATA_WIDTH/8  write strobes
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
- rsp_resp  out  2  BRESP/RRESP of the transaction
- rsp_write  out  1  echoes cmd_write of the transaction
- m_axi_awaddr / awvalid / awready  out / out / in  ADDR_WIDTH / 1 / 1  write address channel
- m_axi_wdata / wstrb / wvalid / wready  out / out / out / in  DATA_WIDTH / DATA_WIDTH/8 / 1 / 1  write data channel
- m_axi_bresp / bvalid / bready  in / in / out  2 / 1 / 1  write response channel
- m_axi_araddr / arvalid / arready  out / out / in  ADDR_WIDTH / 1 / 1  read address channel
- m_axi_rdata / rresp / rvalid / rready  in / in / in / out  DATA_WIDTH / 2 / 1 / 1  read data channel
- timeout_err  out  1  sticky watchdog flag (tied 0 when the feature is out)

## Operation
- FSM states:
  - IDLE: cmd_ready=1. A cmd handshake latches addr, wdata, wstrb and write into registers. Next state is WR_REQ (write) or RD_REQ (read).
  - WR_REQ: awvalid and wvalid are asserted together. Each drops independently on its own handshake; aw_done and w_done flags track completion. Go to WR_RESP when both are done, including the case where both handshake in the same cycle.
  - WR_RESP: bready=1. On bvalid, capture bresp and force rdata=0, then go to RSP.
  - RD_REQ: arvalid=1 until arready, then go to RD_DATA.
  - RD_DATA: rready=1. On rvalid, capture rdata and rresp, then go to RSP.
  - RSP: rsp_valid=1 with stable rsp_* fields until rsp_ready, then go to IDLE.
- Address, data and strobes stay stable while the corresponding valid is high. Valid never drops before its handshake.
- bready and rready are high only in WR_RESP and RD_DATA respectively. bvalid or rvalid seen in any other state is ignored.
- A nonzero resp (SLVERR/DECERR) is passed through unchanged. It does not alter FSM flow.
- Reset, asserted at any time: the FSM goes to IDLE immediately and asynchronously, and every output returns to its reset value. A transaction in flight is abandoned with no response.

## Timing
- Reset values: cmd_ready=0 while ap_rst_n=0 and 1 in IDLE afterwards. All other outputs (valids, readies, addr, data, strb, rsp_*, timeout_err) are 0.
- All AXI and rsp outputs are registered; there is no combinational path from input to output.
- Cycle counts with a zero-wait slave and rsp_ready tied high, where cycle 0 is the cmd handshake:
  - Write: aw/wvalid high in cycle 1, bready high in cycle 2, rsp_valid in cycle 3, cmd_ready again in cycle 4.
  - Read: arvalid in cycle 1, rready in cycle 2, rsp_valid in cycle 3.
- Back-to-back throughput is one command every 4 cycles minimum.
- cmd_ready is 0 in every state except IDLE.

## Configuration
- AXIL_MASTER_TIMEOUT_EN defined:
  - A 16-bit counter clears on entry to WR_REQ or RD_REQ and increments each cycle the FSM sits in WR_REQ, WR_RESP, RD_REQ or RD_DATA.
  - When the count reaches TIMEOUT_CYCLES, timeout_err is set. It stays set until reset.
  - FSM behaviour is otherwise unchanged: the block keeps waiting for the slave.
- AXIL_MASTER_TIMEOUT_EN undefined: no counter is built and timeout_err is tied to 0.

## Test plan
- Write addr 0x30, data 0xDEADBEEF, wstrb 0xF, slave zero-wait -> aw/w beat carries those values in cycle 1; rsp_valid in cycle 3 with rsp_resp=0, rsp_write=1, rsp_rdata=0.
- Slave holds awready low 5 cycles and takes W in cycle 1 -> wvalid drops after cycle 1; awvalid stays high with a stable address until its handshake; exactly one bready handshake follows.
- Read addr 0x10, slave returns rdata 0x10142006, rresp=2'b10 after 3 wait cycles -> rsp_rdata=0x10142006, rsp_resp=2'b10, rsp_write=0.
- Hold rsp_ready low 4 cycles -> rsp_valid and rsp fields stay stable, cmd_ready stays 0; a new cmd is accepted the cycle after rsp_ready rises.
- Pulse ap_rst_n low during WR_RESP -> all valids and readies go to 0 immediately; after release the next command completes normally.
- With AXIL_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=8, slave never asserts arready -> timeout_err rises after 8 cycles in RD_REQ, arvalid stays high.

Source files
------------

// File: rtl/axi_lite_master_if.sv
// -----------------------------------------------------------------------------
// axi_lite_master_if
// AXI4-Lite bus bundle between the register-bus initiator and its slave.
//
// Parameters:
//   DATA_WIDTH  data bus width (32)
//   ADDR_WIDTH  address bus width
//
// Signals (direction as seen by the master modport):
//   awaddr/awvalid out, awready in        write address channel
//   wdata/wstrb/wvalid out, wready in     write data channel
//   bresp/bvalid in, bready out           write response channel
//   araddr/arvalid out, arready in        read address channel
//   rdata/rresp/rvalid in, rready out     read data channel
// -----------------------------------------------------------------------------
interface axi_lite_master_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]     awaddr;
   logic                      awvalid;
   logic                      awready;
   logic [DATA_WIDTH-1:0]     wdata;
   logic [DATA_WIDTH/8-1:0]   wstrb;
   logic                      wvalid;
   logic                      wready;
   logic [1:0]                bresp;
   logic                      bvalid;
   logic                      bready;
   logic [ADDR_WIDTH-1:0]     araddr;
   logic                      arvalid;
   logic                      arready;
   logic [DATA_WIDTH-1:0]     rdata;
   logic [1:0]                rresp;
   logic                      rvalid;
   logic                      rready;

   modport master (
      output awaddr, awvalid, input awready,
      output wdata, wstrb, wvalid, input wready,
      input bresp, bvalid, output bready,
      output araddr, arvalid, input arready,
      input rdata, rresp, rvalid, output rready
   );

   modport slave (
      input awaddr, awvalid, output awready,
      input wdata, wstrb, wvalid, output wready,
      output bresp, bvalid, input bready,
      input araddr, arvalid, output arready,
      output rdata, rresp, rvalid, input rready
   );
endinterface

// File: rtl/axi_lite_master.sv
// -----------------------------------------------------------------------------
// axi_lite_master
// Single-outstanding AXI4-Lite initiator. Each accepted command becomes one
// AXI-Lite write or read; each command yields exactly one response on the
// rsp_* valid/ready port. Every output is driven straight from a register.
//
// Ports:
//   ap_clk, ap_rst_n              clock, asynchronous active-low reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_write/addr/wdata/wstrb    command payload (1 = write)
//   rsp_valid/rsp_ready           response handshake
//   rsp_rdata/rsp_resp/rsp_write  response payload (rdata is 0 for writes)
//   m_axi                         AXI-Lite bus (axi_lite_master_if.master)
//   timeout_err                   sticky watchdog flag
//
// Optional feature: define AXIL_MASTER_TIMEOUT_EN to build the watchdog that
// sets timeout_err after TIMEOUT_CYCLES cycles waiting on the slave. Without
// it timeout_err is tied to 0.
// -----------------------------------------------------------------------------
module axi_lite_master #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                    ap_clk,
   input  logic                    ap_rst_n,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic [1:0]              rsp_resp,
   output logic                    rsp_write,
   axi_lite_master_if.master       m_axi,
   output logic                    timeout_err
);
   typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP} state_t;

   state_t                  state_reg, state_next;
   logic                    cmd_ready_reg, cmd_ready_next;
   logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
   logic [DATA_WIDTH-1:0]   wdata_reg, wdata_next;
   logic [DATA_WIDTH/8-1:0] wstrb_reg, wstrb_next;
   logic                    write_reg, write_next;
   logic                    awvalid_reg, awvalid_next;
   logic                    wvalid_reg, wvalid_next;
   logic                    bready_reg, bready_next;
   logic                    arvalid_reg, arvalid_next;
   logic                    rready_reg, rready_next;
   logic                    aw_done_reg, aw_done_next;
   logic                    w_done_reg, w_done_next;
   logic                    rsp_valid_reg, rsp_valid_next;
   logic [DATA_WIDTH-1:0]   rsp_rdata_reg, rsp_rdata_next;
   logic [1:0]              rsp_resp_reg, rsp_resp_next;
   logic                    rsp_write_reg, rsp_write_next;
   logic                    aw_hs, w_hs;

   assign aw_hs = awvalid_reg && m_axi.awready;
   assign w_hs  = wvalid_reg && m_axi.wready;

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_reg     <= IDLE;
         cmd_ready_reg <= 1'b0;
         addr_reg      <= '0;
         wdata_reg     <= '0;
         wstrb_reg     <= '0;
         write_reg     <= 1'b0;
         awvalid_reg   <= 1'b0;
         wvalid_reg    <= 1'b0;
         bready_reg    <= 1'b0;
         arvalid_reg   <= 1'b0;
         rready_reg    <= 1'b0;
         aw_done_reg   <= 1'b0;
         w_done_reg    <= 1'b0;
         rsp_valid_reg <= 1'b0;
         rsp_rdata_reg <= '0;
         rsp_resp_reg  <= 2'b00;
         rsp_write_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cmd_ready_reg <= cmd_ready_next;
         addr_reg      <= addr_next;
         wdata_reg     <= wdata_next;
         wstrb_reg     <= wstrb_next;
         write_reg     <= write_next;
         awvalid_reg   <= awvalid_next;
         wvalid_reg    <= wvalid_next;
         bready_reg    <= bready_next;
         arvalid_reg   <= arvalid_next;
         rready_reg    <= rready_next;
         aw_done_reg   <= aw_done_next;
         w_done_reg    <= w_done_next;
         rsp_valid_reg <= rsp_valid_next;
         rsp_rdata_reg <= rsp_rdata_next;
         rsp_resp_reg  <= rsp_resp_next;
         rsp_write_reg <= rsp_write_next;
      end
   end

   // Next-state logic also computes the next value of every registered output,
   // so outputs change on the same edge as the state they belong to.
   always_comb begin
      state_next     = state_reg;
      cmd_ready_next = cmd_ready_reg;
      addr_next      = addr_reg;
      wdata_next     = wdata_reg;
      wstrb_next     = wstrb_reg;
      write_next     = write_reg;
      awvalid_next   = awvalid_reg;
      wvalid_next    = wvalid_reg;
      bready_next    = bready_reg;
      arvalid_next   = arvalid_reg;
      rready_next    = rready_reg;
      aw_done_next   = aw_done_reg;
      w_done_next    = w_done_reg;
      rsp_valid_next = rsp_valid_reg;
      rsp_rdata_next = rsp_rdata_reg;
      rsp_resp_next  = rsp_resp_reg;
      rsp_write_next = rsp_write_reg;
      unique case (state_reg)
         IDLE: begin
            if (cmd_valid && cmd_ready_reg) begin
               addr_next      = cmd_addr;
               wdata_next     = cmd_wdata;
               wstrb_next     = cmd_wstrb;
               write_next     = cmd_write;
               cmd_ready_next = 1'b0;
               aw_done_next   = 1'b0;
               w_done_next    = 1'b0;
               if (cmd_write) begin
                  awvalid_next = 1'b1;
                  wvalid_next  = 1'b1;
                  state_next   = WR_REQ;
               end else begin
                  arvalid_next = 1'b1;
                  state_next   = RD_REQ;
               end
            end else begin
               // Raises cmd_ready on the first edge after reset release.
               cmd_ready_next = 1'b1;
            end
         end
         WR_REQ: begin
            if (aw_hs) begin
               awvalid_next = 1'b0;
               aw_done_next = 1'b1;
            end
            if (w_hs) begin
               wvalid_next = 1'b0;
               w_done_next = 1'b1;
            end
            // Handshakes completing this cycle count as done, so a joint
            // AW/W handshake moves on without an extra cycle.
            if ((aw_done_reg || aw_hs) && (w_done_reg || w_hs)) begin
               bready_next = 1'b1;
               state_next  = WR_RESP;
            end
         end
         WR_RESP: begin
            if (m_axi.bvalid) begin
               bready_next    = 1'b0;
               rsp_valid_next = 1'b1;
               rsp_resp_next  = m_axi.bresp;
               rsp_rdata_next = '0;
               rsp_write_next = write_reg;
               state_next     = RSP;
            end
         end
         RD_REQ: begin
            if (m_axi.arready) begin
               arvalid_next = 1'b0;
               rready_next  = 1'b1;
               state_next   = RD_DATA;
            end
         end
         RD_DATA: begin
            if (m_axi.rvalid) begin
               rready_next    = 1'b0;
               rsp_valid_next = 1'b1;
               rsp_resp_next  = m_axi.rresp;
               rsp_rdata_next = m_axi.rdata;
               rsp_write_next = write_reg;
               state_next     = RSP;
            end
         end
         RSP: begin
            if (rsp_ready) begin
               rsp_valid_next = 1'b0;
               cmd_ready_next = 1'b1;
               state_next     = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign cmd_ready     = cmd_ready_reg;
   assign rsp_valid     = rsp_valid_reg;
   assign rsp_rdata     = rsp_rdata_reg;
   assign rsp_resp      = rsp_resp_reg;
   assign rsp_write     = rsp_write_reg;
   assign m_axi.awaddr  = addr_reg;
   assign m_axi.awvalid = awvalid_reg;
   assign m_axi.wdata   = wdata_reg;
   assign m_axi.wstrb   = wstrb_reg;
   assign m_axi.wvalid  = wvalid_reg;
   assign m_axi.bready  = bready_reg;
   assign m_axi.araddr  = addr_reg;
   assign m_axi.arvalid = arvalid_reg;
   assign m_axi.rready  = rready_reg;

`ifdef AXIL_MASTER_TIMEOUT_EN
   localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

   logic [15:0] wd_cnt_reg;
   logic        timeout_err_reg;
   logic        waiting;

   assign waiting = (state_reg == WR_REQ) || (state_reg == WR_RESP) ||
                    (state_reg == RD_REQ) || (state_reg == RD_DATA);

   // Flag is set on the edge the count reaches the limit, i.e. visible right
   // after TIMEOUT_CYCLES cycles spent waiting. The count saturates.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         wd_cnt_reg      <= 16'd0;
         timeout_err_reg <= 1'b0;
      end else if (state_reg == IDLE && state_next != IDLE) begin
         wd_cnt_reg <= 16'd0;
      end else if (waiting) begin
         if (wd_cnt_reg != 16'hFFFF) begin
            wd_cnt_reg <= wd_cnt_reg + 16'd1;
         end
         if (wd_cnt_reg + 16'd1 == TIMEOUT_LIMIT) begin
            timeout_err_reg <= 1'b1;
         end
      end
   end

   assign timeout_err = timeout_err_reg;
`else
   assign timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_axi_lite_master.sv
`timescale 1ns/1ps
module tb_axi_lite_master;
   logic        ap_clk = 1'b0;
   logic        ap_rst_n;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic        rsp_valid, rsp_ready, rsp_write;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic        timeout_err;

   always #5 ap_clk = ~ap_clk;

`ifdef AXIL_MASTER_TIMEOUT_EN
   localparam int TO_CYCLES = 8;
`else
   localparam int TO_CYCLES = 1024;
`endif

   axi_lite_master_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) m_axi_bus ();

   axi_lite_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO_CYCLES)) dut (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_resp(rsp_resp), .rsp_write(rsp_write),
      .m_axi(m_axi_bus), .timeout_err(timeout_err)
   );

   int tests = 0;
   int fails = 0;
   logic [31:0] slv_mem [16];   // slave register file
   logic [31:0] ref_mem [16];   // expected register contents

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference: a register file with byte strobes; returns read data, 0 for writes.
   function automatic logic [31:0] ref_access(input logic wr, input logic [31:0] addr,
                                              input logic [31:0] wdata, input logic [3:0] strb);
      int idx;
      logic [31:0] word;
      idx  = int'(addr[5:2]);
      word = ref_mem[idx];
      if (!wr) return word;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) word[8*b +: 8] = wdata[8*b +: 8];
      end
      ref_mem[idx] = word;
      return 32'h0;
   endfunction

   function automatic logic [31:0] outs_vec();
      return {17'd0, cmd_ready, rsp_valid, |rsp_rdata, |rsp_resp, rsp_write, timeout_err,
              m_axi_bus.awvalid, m_axi_bus.wvalid, m_axi_bus.bready, m_axi_bus.arvalid,
              m_axi_bus.rready, |m_axi_bus.awaddr, |m_axi_bus.wdata, |m_axi_bus.wstrb};
   endfunction

   task automatic slave_idle();
      m_axi_bus.awready = 1'b0; m_axi_bus.wready = 1'b0; m_axi_bus.bvalid = 1'b0;
      m_axi_bus.bresp = 2'b00;  m_axi_bus.arready = 1'b0; m_axi_bus.rvalid = 1'b0;
      m_axi_bus.rdata = 32'h0;  m_axi_bus.rresp = 2'b00;  rsp_ready = 1'b0;
   endtask

   // One command, with the bench acting as slave and response consumer.
   // Called at a falling edge; every decision is made at falling edges, so a
   // handshake happens on the next rising edge when valid and ready are both high.
   task automatic run_txn(input string name, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb,
                          input int aw_d, input int w_d, input int b_d, input int ar_d,
                          input int r_d, input int rsp_d, input logic [1:0] resp,
                          input logic [31:0] exp_rdata);
      int cyc = 0, lat = -1, perr = 0, serr = 0, rerr = 0;
      int aw_n = 0, w_n = 0, b_n = 0, ar_n = 0, r_n = 0;
      int aw_w = 0, w_w = 0, b_w = 0, ar_w = 0, r_w = 0, rsp_w = 0;
      logic done = 1'b0, zero;
      logic [31:0] cap_addr = 32'h0, cap_wdata = 32'h0, mask, s_rdata = 32'h0;
      logic [3:0]  cap_wstrb = 4'h0;
      logic [1:0]  s_resp = 2'b00;
      logic        s_write = 1'b0;
      zero = (aw_d == 0 && w_d == 0 && b_d == 0 && ar_d == 0 && r_d == 0 && rsp_d == 0);
      for (int i = 0; i < 20 && !cmd_ready; i++) @(negedge ap_clk);
      check({name, " cmd_ready_idle"}, 32'(cmd_ready), 32'h1);
      if (!cmd_ready) return;
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = strb;
      while (!done && cyc < 200) begin
         @(negedge ap_clk);
         cyc++;
         cmd_valid = 1'b0;
         if (cmd_ready) rerr++;
         // write response (uses completion flags from earlier cycles)
         if (aw_n == 1 && w_n == 1 && b_n == 0) begin
            if (b_w < b_d) begin m_axi_bus.bvalid = 1'b0; b_w++; end
            else begin
               m_axi_bus.bvalid = 1'b1; m_axi_bus.bresp = resp;
               if (m_axi_bus.bready) begin
                  b_n++;
                  mask = {{8{cap_wstrb[3]}}, {8{cap_wstrb[2]}}, {8{cap_wstrb[1]}}, {8{cap_wstrb[0]}}};
                  slv_mem[cap_addr[5:2]] = (slv_mem[cap_addr[5:2]] & ~mask) | (cap_wdata & mask);
               end
            end
         end else begin
            m_axi_bus.bvalid = 1'b0;
            if (m_axi_bus.bready) perr++;
         end
         // read data
         if (ar_n == 1 && r_n == 0) begin
            if (r_w < r_d) begin m_axi_bus.rvalid = 1'b0; r_w++; end
            else begin
               m_axi_bus.rvalid = 1'b1; m_axi_bus.rresp = resp;
               m_axi_bus.rdata = slv_mem[cap_addr[5:2]];
               if (m_axi_bus.rready) r_n++;
            end
         end else begin
            m_axi_bus.rvalid = 1'b0;
            if (m_axi_bus.rready) perr++;
         end
         // write address
         if (m_axi_bus.awvalid) begin
            if (!wr || aw_n != 0) perr++;
            if (m_axi_bus.awaddr !== addr) serr++;
            if (aw_w < aw_d) begin m_axi_bus.awready = 1'b0; aw_w++; end
            else begin m_axi_bus.awready = 1'b1; aw_n++; cap_addr = m_axi_bus.awaddr; end
         end else begin
            m_axi_bus.awready = 1'b0;
            if (wr && aw_n == 0) perr++;
         end
         // write data
         if (m_axi_bus.wvalid) begin
            if (!wr || w_n != 0) perr++;
            if (m_axi_bus.wdata !== wdata || m_axi_bus.wstrb !== strb) serr++;
            if (w_w < w_d) begin m_axi_bus.wready = 1'b0; w_w++; end
            else begin
               m_axi_bus.wready = 1'b1; w_n++;
               cap_wdata = m_axi_bus.wdata; cap_wstrb = m_axi_bus.wstrb;
            end
         end else begin
            m_axi_bus.wready = 1'b0;
            if (wr && w_n == 0) perr++;
         end
         // read address
         if (m_axi_bus.arvalid) begin
            if (wr || ar_n != 0) perr++;
            if (m_axi_bus.araddr !== addr) serr++;
            if (ar_w < ar_d) begin m_axi_bus.arready = 1'b0; ar_w++; end
            else begin m_axi_bus.arready = 1'b1; ar_n++; cap_addr = m_axi_bus.araddr; end
         end else begin
            m_axi_bus.arready = 1'b0;
            if (!wr && ar_n == 0) perr++;
         end
         // response port
         if (rsp_valid) begin
            if (lat < 0) begin
               lat = cyc; s_rdata = rsp_rdata; s_resp = rsp_resp; s_write = rsp_write;
               if (wr ? (b_n == 0) : (r_n == 0)) perr++;
            end else if ({rsp_rdata, rsp_resp, rsp_write} !== {s_rdata, s_resp, s_write}) begin
               serr++;
            end
            if (rsp_w < rsp_d) begin rsp_ready = 1'b0; rsp_w++; end
            else begin rsp_ready = 1'b1; done = 1'b1; end
         end else begin
            rsp_ready = 1'b0;
         end
      end
      check({name, " completed"}, 32'(done), 32'h1);
      check({name, " rsp_rdata"}, s_rdata, wr ? 32'h0 : exp_rdata);
      check({name, " rsp_resp"}, 32'(s_resp), 32'(resp));
      check({name, " rsp_write"}, 32'(s_write), 32'(wr));
      check({name, " handshake_count"}, wr ? 32'(aw_n * 100 + w_n * 10 + b_n) : 32'(ar_n * 10 + r_n),
            wr ? 32'd111 : 32'd11);
      check({name, " protocol_errs"}, 32'(perr), 32'd0);
      check({name, " stability_errs"}, 32'(serr), 32'd0);
      check({name, " cmd_ready_busy"}, 32'(rerr), 32'd0);
      @(negedge ap_clk);
      slave_idle();
      if (zero) begin
         check({name, " rsp_latency"}, 32'(lat), 32'd3);
         check({name, " cmd_ready_cycle4"}, 32'(cmd_ready), 32'h1);
      end
      $display("[TB] %s wr=%0d addr=0x%02h wdata=0x%08h strb=0x%h rdata=0x%08h resp=%0d lat=%0d cycles=%0d",
               name, wr, addr[7:0], wdata, strb, s_rdata, s_resp, lat, cyc);
   endtask

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      int          aw_d, w_d, b_d, ar_d, r_d, rsp_d;
      logic [1:0]  resp;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[9];

   initial begin
      logic        wr;
      logic [31:0] addr, wdata, exp;
      logic [3:0]  strb;
      logic [1:0]  resp;
      int          d[6];
      int          first, arlow;

      vecs[0] = '{1'b1, 32'h30, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 0, 2'b00, 32'h0};
      vecs[1] = '{1'b1, 32'h10, 32'h10142006, 4'hF, 0, 0, 0, 0, 0, 0, 2'b00, 32'h0};
      vecs[2] = '{1'b0, 32'h10, 32'h0,        4'h0, 0, 0, 0, 0, 3, 0, 2'b10, 32'h10142006};
      vecs[3] = '{1'b1, 32'h20, 32'hAABBCCDD, 4'hF, 5, 0, 0, 0, 0, 0, 2'b00, 32'h0};
      vecs[4] = '{1'b1, 32'h20, 32'h11223344, 4'h5, 0, 3, 2, 0, 0, 0, 2'b01, 32'h0};
      vecs[5] = '{1'b0, 32'h20, 32'h0,        4'h0, 0, 0, 0, 2, 0, 0, 2'b11, 32'hAA22CC44};
      vecs[6] = '{1'b0, 32'h30, 32'h0,        4'h0, 0, 0, 0, 0, 0, 4, 2'b00, 32'hDEADBEEF};
      vecs[7] = '{1'b0, 32'h3C, 32'h0,        4'h0, 0, 0, 0, 0, 0, 0, 2'b00, 32'h0};
      vecs[8] = '{1'b0, 32'h30, 32'h0,        4'h0, 0, 0, 0, 0, 0, 0, 2'b01, 32'hDEADBEEF};

      for (int i = 0; i < 16; i++) begin slv_mem[i] = 32'h0; ref_mem[i] = 32'h0; end
      ap_rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
      cmd_addr = 32'h0; cmd_wdata = 32'h0; cmd_wstrb = 4'h0;
      slave_idle();

      // reset state
      repeat (2) @(negedge ap_clk);
      check("reset_outputs", outs_vec(), 32'h0);
      ap_rst_n = 1'b1;
      @(negedge ap_clk);
      check("cmd_ready_after_reset", 32'(cmd_ready), 32'h1);

      // directed table
      for (int i = 0; i < 9; i++) begin
         exp = ref_access(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb);
         run_txn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb,
                 vecs[i].aw_d, vecs[i].w_d, vecs[i].b_d, vecs[i].ar_d, vecs[i].r_d,
                 vecs[i].rsp_d, vecs[i].resp, vecs[i].exp_rdata);
      end

      // reset pulse while waiting for the write response
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h08; cmd_wdata = 32'h55AA55AA; cmd_wstrb = 4'hF;
      m_axi_bus.awready = 1'b1; m_axi_bus.wready = 1'b1;
      @(negedge ap_clk);
      cmd_valid = 1'b0;
      check("rst_seq awvalid_c1", 32'({m_axi_bus.awvalid, m_axi_bus.wvalid}), 32'h3);
      @(negedge ap_clk);
      check("rst_seq bready_c2", 32'(m_axi_bus.bready), 32'h1);
      #2 ap_rst_n = 1'b0;
      #1 check("rst_seq async_clear", outs_vec(), 32'h0);
      slave_idle();
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      @(negedge ap_clk);
      exp = ref_access(1'b1, 32'h08, 32'h0BADF00D, 4'hF);
      run_txn("post_reset_wr", 1'b1, 32'h08, 32'h0BADF00D, 4'hF, 0, 0, 0, 0, 0, 0, 2'b00, exp);
      exp = ref_access(1'b0, 32'h08, 32'h0, 4'h0);
      run_txn("post_reset_rd", 1'b0, 32'h08, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0, 2'b00, exp);

      // randomized commands checked against the register-file reference
      for (int n = 0; n < 40; n++) begin
         wr    = 1'($urandom_range(0, 1));
         addr  = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
         wdata = $urandom;
         strb  = 4'($urandom_range(0, 15));
         resp  = 2'($urandom_range(0, 3));
         for (int k = 0; k < 6; k++) d[k] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 3));
         exp = ref_access(wr, addr, wdata, strb);
         run_txn($sformatf("rand%0d", n), wr, addr, wdata, strb,
                 d[0], d[1], d[2], d[3], d[4], d[5], resp, exp);
      end

      // slave never accepts the read address: watchdog behaviour
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h04;
      first = -1; arlow = 0;
      for (int c = 1; c <= 14; c++) begin
         @(negedge ap_clk);
         cmd_valid = 1'b0;
         if (timeout_err && first < 0) first = c;
         if (!m_axi_bus.arvalid) arlow++;
      end
`ifdef AXIL_MASTER_TIMEOUT_EN
      // cycles 1..8 spent in RD_REQ, flag visible from cycle 9
      check("timeout_first_cycle", 32'(first), 32'd9);
`else
      check("timeout_never_set", 32'(first), 32'hFFFF_FFFF);
`endif
      check("timeout_arvalid_held", 32'(arlow), 32'd0);
      ap_rst_n = 1'b0;
      #1 check("timeout_reset_clear", outs_vec(), 32'h0);
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      @(negedge ap_clk);
      exp = ref_access(1'b0, 32'h30, 32'h0, 4'h0);
      run_txn("final_rd", 1'b0, 32'h30, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0, 2'b00, exp);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
